// File: rtl/Asynchronous_FIFO_pkg.sv
// rtl/Asynchronous_FIFO_pkg.sv - shared widths and types for the async FIFO and its read stage
package Asynchronous_FIFO_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int RD_BUF_DEPTH = 3;
    localparam int CNT_WIDTH    = 16;

    typedef logic [CNT_WIDTH-1:0] rd_stage_cnt_t;

endpackage

// File: rtl/rd_stage_buf.sv
// rtl/rd_stage_buf.sv - circular buffer with head/tail pointers and occupancy for the read stage
module rd_stage_buf #(
    parameter  int DATA_WIDTH = Asynchronous_FIFO_pkg::DATA_WIDTH,
    parameter  int BUF_DEPTH  = Asynchronous_FIFO_pkg::RD_BUF_DEPTH,
    localparam int PTR_W      = $clog2(BUF_DEPTH),
    localparam int OCC_W      = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [OCC_W-1:0]      occ
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [OCC_W-1:0]      occ_q, occ_d;

    // Explicit wrap so non-power-of-two depths stay in range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q + OCC_W'(wr_en) - OCC_W'(rd_en);
        if (wr_en) tail_d = ptr_inc(tail_q);
        if (rd_en) head_d = ptr_inc(head_q);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clr) mem_q[tail_q] <= wr_data;
    end

    assign rd_data = mem_q[head_q];
    assign occ     = occ_q;

endmodule

// File: rtl/async_fifo_rd_stage.sv
// rtl/async_fifo_rd_stage.sv - drains the async FIFO into a small buffer and a valid/ready stream
module async_fifo_rd_stage #(
    parameter  int DATA_WIDTH = Asynchronous_FIFO_pkg::DATA_WIDTH,
    parameter  int BUF_DEPTH  = Asynchronous_FIFO_pkg::RD_BUF_DEPTH,
    parameter  int CNT_WIDTH  = Asynchronous_FIFO_pkg::CNT_WIDTH,
    localparam int OCC_W      = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk_rd,
    input  logic                  rst,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_en,
    input  logic                  flush,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    logic                  inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;
    logic [OCC_W-1:0]      occ;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  capture;
    logic                  accept;
    logic                  clr;

    assign clr = rst || flush;

    // Reserve a slot for the in-flight word so a capture always has room.
    assign rd_en   = !clr && !empty && ((int'(occ) + int'(inflight_q)) < BUF_DEPTH);
    assign capture = inflight_q && !clr;
    assign m_valid = (occ != '0);
    assign m_data  = m_valid ? head_data : '0;
    assign accept  = m_valid && m_ready;

    always_comb begin
        inflight_d = rd_en;
        rd_count_d = rd_count_q + CNT_WIDTH'(accept);
    end

    always_ff @(posedge clk_rd) begin
        if (rst) begin
            inflight_q <= 1'b0;
            rd_count_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign rd_count = rd_count_q;

    rd_stage_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk     (clk_rd),
        .clr     (clr),
        .wr_en   (capture),
        .wr_data (data_out),
        .rd_en   (accept),
        .rd_data (head_data),
        .occ     (occ)
    );

    a_no_pop_when_empty: assert property (@(posedge clk_rd) disable iff (rst) !(rd_en && empty));
    a_occ_bound: assert property (@(posedge clk_rd) int'(occ) <= BUF_DEPTH);
    a_no_overflow: assert property (@(posedge clk_rd) disable iff (rst)
        !(capture && (int'(occ) == BUF_DEPTH) && !accept));

endmodule

// File: doc/async_fifo_rd_stage.md
# async_fifo_rd_stage

Read-side drain stage that sits directly downstream of the asynchronous FIFO in the `clk_rd` domain. It issues `rd_en` to the FIFO whenever data is available and local space exists, and absorbs the FIFO's one-cycle read latency into a 3-entry output buffer. It presents the words to the consumer on a valid/ready stream at up to one word per cycle. It also provides a synchronous flush and a delivered-word counter.

## Interface
Parameters:
- `DATA_WIDTH`, default from `Asynchronous_FIFO_pkg` (8): FIFO word width.
- `BUF_DEPTH`, default 3 (`RD_BUF_DEPTH` in package): local buffer entries. Must be ≥ 3 for full throughput.
- `CNT_WIDTH`, default 16: width of the delivered-word counter.

Ports:
- `clk_rd`  in  1  read-domain clock; all logic on its rising edge.
- `rst`  in  1  **one clock; reset is synchronous and active-high**.
- `empty`  in  1  FIFO empty flag, already synchronized to `clk_rd`.
- `data_out`  in  DATA_WIDTH  FIFO read data, valid exactly 1 cycle after an `rd_en` cycle.
- `rd_en`  out  1  FIFO pop request.
- `flush`  in  1  synchronous discard of all buffered and in-flight words.
- `m_valid`  out  1  output word available.
- `m_data`  out  DATA_WIDTH  output word (head of buffer).
- `m_ready`  in  1  consumer accepts when `m_valid && m_ready`.
- `rd_count`  out  CNT_WIDTH  count of words accepted by the consumer.

## Operation
- State:
  - `occ` (0..BUF_DEPTH): buffered words.
  - `inflight` (1 bit): an `rd_en` was issued last cycle.
  - Head and tail pointers mod BUF_DEPTH.
- Pop request: `rd_en = !rst && !flush && !empty && (occ + inflight) < BUF_DEPTH`.
  - Depends only on registered state, `empty`, `flush` and `rst`. There is no combinational path from `m_ready`.
- Capture: if `inflight` was set and no flush is in effect, `data_out` is written at the tail and the tail advances.
- Output: `m_valid = (occ != 0)`; `m_data` is the head entry. An accept advances the head.
- `occ` update:
  - `occ_next = occ + capture − accept`.
  - A simultaneous capture and accept leaves `occ` unchanged. This is legal even when `occ == BUF_DEPTH−1`.
- `rd_count` increments by 1 per accept and wraps modulo 2^CNT_WIDTH.
- Flush:
  - Next cycle: `occ = 0`, pointers = 0, `m_valid = 0`.
  - A word in flight at the flush cycle (its `rd_en` was issued the cycle before `flush`) is discarded when it arrives.
  - An accept in the same cycle as `flush` still counts in `rd_count`.
  - `rd_count` is not cleared by `flush`.
- Pointer wrap: pointers increment modulo BUF_DEPTH and return to 0 after BUF_DEPTH−1. BUF_DEPTH need not be a power of two.
- Errors (assertions, not RTL behaviour):
  - `rd_en && empty` never occurs.
  - `occ` never exceeds BUF_DEPTH.
  - A capture never occurs when `occ == BUF_DEPTH` without a same-cycle accept.

## Timing
- Reset (synchronous, sampled on `clk_rd`): `rd_en=0`, `m_valid=0`, `m_data=0`, `rd_count=0`, `occ=0`, `inflight=0`, pointers 0.
  - An `rst` asserted mid-operation discards buffered and in-flight words exactly as a flush does, and also clears `rd_count`.
- Latency from FIFO non-empty to the output word:
  - cycle N: `empty=0` → `rd_en=1`.
  - N+1: `data_out` captured.
  - N+2: `m_valid=1`.
- Throughput: 1 word/cycle sustained while `m_ready=1` and the FIFO stays non-empty.
- Backpressure: with `m_ready=0` held, at most BUF_DEPTH words are popped; `rd_en` then stays 0.
- `m_valid` and `m_data` are stable while `m_valid && !m_ready` (no flush).

## Structure
- `Asynchronous_FIFO_pkg` gains `RD_BUF_DEPTH` (3) and a `rd_stage_cnt_t` typedef (logic [CNT_WIDTH-1:0]). `DATA_WIDTH` is reused from the package.
- One sub-module is natural: `rd_stage_buf`, the circular buffer holding the storage array, head/tail pointers, `occ` and the write/read strobes.
- The top level holds the `rd_en` issue logic, the `inflight` flag, flush/drop handling and `rd_count`.

## Test plan
- Reset, then FIFO preloaded with 0x11, 0x22, 0x33 and `m_ready=1` → `m_data` shows 0x11, 0x22, 0x33 on consecutive cycles. The first `m_valid` comes 2 cycles after the first `rd_en`. `rd_count` ends at 3.
- FIFO holds 10 words, `m_ready=0` → exactly 3 `rd_en` pulses, `occ=3`, `rd_en` held 0. Raise `m_ready` → all 10 words delivered in order with no gaps after the first.
- Flush asserted the cycle after an `rd_en`, with 2 words buffered → next cycle `m_valid=0`, the in-flight word is discarded, and the next popped word appears as the first output. `rd_count` is unchanged.
- `empty` toggling every cycle with `m_ready` random → `rd_en` is never high when `empty=1`. The output order matches the FIFO order exactly; the scoreboard compares against a reference queue.
- `rst` pulsed while `occ=2` and a word is in flight → all outputs return to reset values the next cycle, and no stale word appears afterwards.
- `CNT_WIDTH=4`, 17 accepts → `rd_count` reads 1.
